// File: rtl/fifo_pkg.sv
// Shared defaults for the synchronous FIFO and a helper to derive the
// occupancy width from a depth.
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 16;
    localparam int FIFO_DEPTH      = 32;
    localparam int FIFO_CNT_WIDTH  = 6;

    // Occupancy must represent 0..depth inclusive, hence the extra bit.
    function automatic int cnt_width_for(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : fifo_pkg

// File: rtl/rise_pulse.sv
// Rising-edge detector: turns a level request into a single-cycle pulse.
// The registered copy clears on reset so a level already high at release fires once.
module rise_pulse (
    input  logic clk,
    input  logic rst_n,
    input  logic level_i,
    output logic pulse_o
);

    logic level_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level_i;
        end
    end

    assign pulse_o = level_i & ~level_q;

endmodule : rise_pulse

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with edge-qualified push/pop
// requests, registered empty/full flags and an occupancy counter.
module sync_fifo
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH,
    parameter int DEPTH      = FIFO_DEPTH,
    parameter int CNT_WIDTH  = FIFO_CNT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] in,
    input  logic                  wr_en_in,
    input  logic                  rd_en_in,
    output logic [DATA_WIDTH-1:0] out,
    output logic                  empty,
    output logic                  full,
    output logic [CNT_WIDTH-1:0]  counter
);

    localparam int PTR_W = $clog2(DEPTH);

    localparam logic [PTR_W-1:0]     PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(DEPTH);

    logic push_req;
    logic pop_req;
    logic push_acc;
    logic pop_acc;

    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q,  count_d;
    logic                 empty_q,  empty_d;
    logic                 full_q,   full_d;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    rise_pulse u_push_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (wr_en_in),
        .pulse_o (push_req)
    );

    rise_pulse u_pop_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .level_i (rd_en_in),
        .pulse_o (pop_req)
    );

    // A request is a one-cycle pulse; it is accepted only when the flag
    // registered at the start of the cycle allows it, otherwise it is lost.
    assign push_acc = push_req & ~full_q;
    assign pop_acc  = pop_req  & ~empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        case ({push_acc, pop_acc})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase

        empty_d = (count_d == '0);
        full_d  = (count_d == CNT_FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= empty_d;
            full_q   <= full_d;
        end
    end

    // Storage carries no reset; stale words are masked by the empty flag.
    always_ff @(posedge clk) begin
        if (push_acc) begin
            mem[wr_ptr_q] <= in;
        end
    end

    assign out     = empty_q ? '0 : mem[rd_ptr_q];
    assign empty   = empty_q;
    assign full    = full_q;
    assign counter = count_q;

endmodule : sync_fifo

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo: a vector table for single-cycle behaviour
// plus hand-written sequences for fill, wrap and reset corner cases.
module tb_sync_fifo;

    localparam int DW = 16;
    localparam int DP = 32;
    localparam int CW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] din;
    logic          wr_en;
    logic          rd_en;
    logic [DW-1:0] dout;
    logic          empty;
    logic          full;
    logic [CW-1:0] counter;

    int checks   = 0;
    int failures = 0;

    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic          wr;
        logic          rd;
        logic [DW-1:0] din;
        logic [DW-1:0] exp_out;
        logic [CW-1:0] exp_cnt;
        logic          exp_empty;
        logic          exp_full;
    } vec_t;

    vec_t vecs [16];

    sync_fifo #(
        .DATA_WIDTH (DW),
        .DEPTH      (DP),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in       (din),
        .wr_en_in (wr_en),
        .rd_en_in (rd_en),
        .out      (dout),
        .empty    (empty),
        .full     (full),
        .counter  (counter)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_state(input string name, input logic [DW-1:0] e_out,
                               input logic [CW-1:0] e_cnt, input logic e_empty,
                               input logic e_full);
        check({name, ".out"},   32'(dout),    32'(e_out));
        check({name, ".cnt"},   32'(counter), 32'(e_cnt));
        check({name, ".empty"}, 32'(empty),   32'(e_empty));
        check({name, ".full"},  32'(full),    32'(e_full));
    endtask

    task automatic do_reset();
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One rising edge on wr_en, then the level drops so the next push can fire.
    task automatic push(input logic [DW-1:0] d);
        din   = d;
        wr_en = 1'b1;
        tick();
        wr_en = 1'b0;
        tick();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
        tick();
    endtask

    initial begin
        // wr rd din exp_out exp_cnt empty full
        vecs[0]  = '{1'b0, 1'b0, 16'h0000, 16'h0000, 6'd0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 16'hA5A5, 16'hA5A5, 6'd1, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 16'h1111, 16'hA5A5, 6'd1, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b0, 16'h1111, 16'hA5A5, 6'd1, 1'b0, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 16'h1234, 16'hA5A5, 6'd2, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 16'h0000, 16'h1234, 6'd1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b1, 16'h0000, 16'h1234, 6'd1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 16'h0000, 16'h1234, 6'd1, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 16'hBEEF, 16'hBEEF, 6'd1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 16'h0000, 16'hBEEF, 6'd1, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 6'd0, 1'b1, 1'b0};
        vecs[11] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 6'd0, 1'b1, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 6'd0, 1'b1, 1'b0};
        vecs[13] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 6'd0, 1'b1, 1'b0};
        vecs[14] = '{1'b1, 1'b1, 16'h0042, 16'h0042, 6'd1, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b0, 16'h0000, 16'h0042, 6'd1, 1'b0, 1'b0};

        // Reset state
        wr_en = 1'b0;
        rd_en = 1'b0;
        din   = '0;
        rst_n = 1'b0;
        tick();
        check_state("reset", 16'h0000, 6'd0, 1'b1, 1'b0);
        tick();
        rst_n = 1'b1;

        // Table: single push, level hold, pops, simultaneous ops, empty pops
        for (int i = 0; i < 16; i++) begin
            wr_en = vecs[i].wr;
            rd_en = vecs[i].rd;
            din   = vecs[i].din;
            tick();
            check_state($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_cnt,
                        vecs[i].exp_empty, vecs[i].exp_full);
        end

        // Level held for 10 clocks yields one push
        do_reset();
        din   = 16'h7777;
        wr_en = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        check_state("hold10", 16'h7777, 6'd1, 1'b0, 1'b0);
        wr_en = 1'b0;
        tick();

        // Fill to full, drop an extra push, then push+pop while full
        do_reset();
        for (int i = 0; i < DP; i++) push(16'(i));
        check_state("filled", 16'h0000, 6'd32, 1'b0, 1'b1);
        push(16'h0100);
        check_state("drop33", 16'h0000, 6'd32, 1'b0, 1'b1);
        din   = 16'hDEAD;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state("full_pushpop", 16'h0001, 6'd31, 1'b0, 1'b0);
        tick();
        for (int i = 1; i < DP; i++) begin
            check($sformatf("drain%0d", i), 32'(dout), 32'(i));
            pop();
        end
        check_state("drained", 16'h0000, 6'd0, 1'b1, 1'b0);

        // Five entries, simultaneous push and pop
        do_reset();
        for (int i = 0; i < 5; i++) push(16'(10 + i));
        din   = 16'h0099;
        wr_en = 1'b1;
        rd_en = 1'b1;
        tick();
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_state("five_both", 16'd11, 6'd5, 1'b0, 1'b0);
        tick();
        exp_q = '{16'd11, 16'd12, 16'd13, 16'd14, 16'h0099};
        while (exp_q.size() > 0) begin
            check("five_order", 32'(dout), 32'(exp_q.pop_front()));
            pop();
        end
        check_state("five_empty", 16'h0000, 6'd0, 1'b1, 1'b0);

        // 40 pushes and 40 pops interleaved across pointer wrap
        do_reset();
        exp_q.delete();
        for (int i = 0; i < 40; i++) begin
            push(16'h0100 + 16'(i));
            exp_q.push_back(16'h0100 + 16'(i));
            if (i >= 3) begin
                check($sformatf("wrap%0d", i), 32'(dout), 32'(exp_q.pop_front()));
                pop();
            end
        end
        check("wrap_cnt", 32'(counter), 32'd3);
        while (exp_q.size() > 0) begin
            check("wrap_tail", 32'(dout), 32'(exp_q.pop_front()));
            pop();
        end
        check_state("wrap_empty", 16'h0000, 6'd0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream, away from any clock edge
        for (int i = 0; i < 4; i++) push(16'h0F00 + 16'(i));
        check("pre_rst_cnt", 32'(counter), 32'd4);
        #1;
        rst_n = 1'b0;
        #1;
        check_state("async_rst", 16'h0000, 6'd0, 1'b1, 1'b0);

        // Write level already high when reset releases acts on the first clock
        din   = 16'h5A5A;
        wr_en = 1'b1;
        #1;
        rst_n = 1'b1;
        tick();
        check_state("rel_push", 16'h5A5A, 6'd1, 1'b0, 1'b0);
        wr_en = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_sync_fifo
